// File: rtl/video_stream_unpacker.sv
// Unpacks 32-bit AXI4-Stream words of packed 24-bit BGR (4 pixels per 3 words) into one pixel per handshake with x/y.
// Optional: define VIDEO_UNPACK_KEEP_CHECK_EN to flag accepted words with partial tkeep in err_keep.
module video_stream_unpacker #(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] frame_count,
  output logic        err_sof,
  output logic        err_eol,
  output logic        err_keep,
  input  logic        err_clear
);

  localparam logic [1:0] PH0  = 2'd0;
  localparam logic [1:0] PH1  = 2'd1;
  localparam logic [1:0] PH2  = 2'd2;
  localparam logic [1:0] PH2B = 2'd3;

  localparam logic [9:0] X_LAST = 10'(X_SIZE - 1);
  localparam logic [9:0] X_TAIL = 10'(X_SIZE - 2);
  localparam logic [8:0] Y_LAST = 9'(Y_SIZE - 1);

  logic [1:0]  st_q, st_d;
  logic [15:0] res_q, res_d;
  logic [23:0] hold_q, hold_d;
  logic        eol_pend_q, eol_pend_d;
  logic [9:0]  px_q, px_d;
  logic [8:0]  py_q, py_d;
  logic [23:0] pix_q, pix_d;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic        vld_q, vld_d;
  logic [15:0] fc_q, fc_d;
  logic        err_sof_q, err_sof_d;
  logic        err_eol_q, err_eol_d;

  logic        out_free, tready, accept;
  logic        sof_resync, is_line_end, early_eol;
  logic [1:0]  st_e;
  logic [9:0]  px_e;
  logic [8:0]  py_e;
  logic [3:0][7:0] bytes;
  logic [23:0] dec_pix;

  function automatic logic [8:0] next_row(input logic [8:0] row);
    return (row == Y_LAST) ? 9'd0 : row + 9'd1;
  endfunction

  function automatic logic [18:0] advance(input logic [9:0] col, input logic [8:0] row);
    if (col == X_LAST) return {10'd0, next_row(row)};
    return {col + 10'd1, row};
  endfunction

  assign bytes = in_stream_tdata;

  always_comb begin
    out_free    = !vld_q || pix_ready;
    tready      = aresetn && out_free && (st_q != PH2B);
    accept      = in_stream_tvalid && tready;
    // A tuser word anywhere but the very start of a frame restarts decoding at (0,0)
    sof_resync  = in_stream_tuser && !(st_q == PH0 && px_q == 10'd0 && py_q == 9'd0);
    st_e        = sof_resync ? PH0   : st_q;
    px_e        = sof_resync ? 10'd0 : px_q;
    py_e        = sof_resync ? 9'd0  : py_q;
    is_line_end = (st_e == PH2) && (px_e == X_TAIL);
    early_eol   = in_stream_tlast && !is_line_end;
    case (st_e)
      PH0:     dec_pix = {bytes[2], bytes[1], bytes[0]};
      PH1:     dec_pix = {bytes[1], bytes[0], res_q[7:0]};
      default: dec_pix = {bytes[0], res_q[15:8], res_q[7:0]};
    endcase
  end

  always_comb begin
    st_d       = st_q;
    res_d      = res_q;
    hold_d     = hold_q;
    eol_pend_d = eol_pend_q;
    px_d       = px_q;
    py_d       = py_q;
    pix_d      = pix_q;
    x_d        = x_q;
    y_d        = y_q;
    vld_d      = vld_q;
    if (accept) begin
      vld_d        = 1'b1;
      pix_d        = dec_pix;
      x_d          = px_e;
      y_d          = py_e;
      {px_d, py_d} = advance(px_e, py_e);
      case (st_e)
        PH0: begin
          st_d  = PH1;
          res_d = {8'd0, bytes[3]};
        end
        PH1: begin
          st_d  = PH2;
          res_d = {bytes[3], bytes[2]};
        end
        default: begin
          st_d   = PH2B;
          res_d  = 16'd0;
          hold_d = {bytes[3], bytes[2], bytes[1]};
        end
      endcase
      if (early_eol) begin
        res_d = 16'd0;
        // The hold pixel is complete, so it still goes out before the line restarts
        if (st_e == PH2) begin
          eol_pend_d = 1'b1;
        end else begin
          st_d = PH0;
          px_d = 10'd0;
          py_d = next_row(py_e);
        end
      end
    end else if (st_q == PH2B && out_free) begin
      vld_d      = 1'b1;
      pix_d      = hold_q;
      x_d        = px_q;
      y_d        = py_q;
      st_d       = PH0;
      eol_pend_d = 1'b0;
      if (eol_pend_q) {px_d, py_d} = {10'd0, next_row(py_q)};
      else            {px_d, py_d} = advance(px_q, py_q);
    end else if (out_free) begin
      vld_d = 1'b0;
    end
  end

  always_comb begin
    fc_d      = fc_q;
    err_sof_d = err_clear ? 1'b0 : err_sof_q;
    err_eol_d = err_clear ? 1'b0 : err_eol_q;
    if (accept && in_stream_tuser) fc_d = fc_q + 16'd1;
    if (accept && sof_resync) err_sof_d = 1'b1;
    if (accept && (early_eol || (is_line_end && !in_stream_tlast))) err_eol_d = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      st_q       <= PH0;
      res_q      <= '0;
      hold_q     <= '0;
      eol_pend_q <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      pix_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      vld_q      <= 1'b0;
      fc_q       <= '0;
      err_sof_q  <= 1'b0;
      err_eol_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      res_q      <= res_d;
      hold_q     <= hold_d;
      eol_pend_q <= eol_pend_d;
      px_q       <= px_d;
      py_q       <= py_d;
      pix_q      <= pix_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vld_q      <= vld_d;
      fc_q       <= fc_d;
      err_sof_q  <= err_sof_d;
      err_eol_q  <= err_eol_d;
    end
  end

`ifdef VIDEO_UNPACK_KEEP_CHECK_EN
  logic err_keep_q, err_keep_d;

  always_comb begin
    err_keep_d = err_clear ? 1'b0 : err_keep_q;
    if (accept && in_stream_tkeep != 4'hF) err_keep_d = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) err_keep_q <= 1'b0;
    else          err_keep_q <= err_keep_d;
  end

  assign err_keep = err_keep_q;
`else
  logic unused_keep;
  assign unused_keep = ^in_stream_tkeep;
  assign err_keep    = 1'b0;
`endif

  assign in_stream_tready = tready;
  assign r                = pix_q[23:16];
  assign g                = pix_q[15:8];
  assign b                = pix_q[7:0];
  assign x                = x_q;
  assign y                = y_q;
  assign pix_valid        = vld_q;
  assign frame_count      = fc_q;
  assign err_sof          = err_sof_q;
  assign err_eol          = err_eol_q;

endmodule

// File: tb/tb_video_stream_unpacker.sv
// Bench for video_stream_unpacker: directed vector table, hand-built corner sequences and random
// streams scored against a byte-queue reference model of the unpacking rules.
module tb_video_stream_unpacker;

  localparam int XS  = 16;
  localparam int YS  = 8;
  localparam int WPL = 3 * XS / 4;
  localparam int K_NONE = 0, K_EOL = 1, K_SOF = 2, K_KEEP = 3;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] in_stream_tdata;
  logic [3:0]  in_stream_tkeep;
  logic        in_stream_tlast, in_stream_tuser, in_stream_tvalid, in_stream_tready;
  logic [7:0]  r, g, b;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        pix_valid, pix_ready;
  logic [15:0] frame_count;
  logic        err_sof, err_eol, err_keep, err_clear;

  always #5 aclk = ~aclk;

  video_stream_unpacker #(.X_SIZE(XS), .Y_SIZE(YS)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_stream_tdata(in_stream_tdata), .in_stream_tkeep(in_stream_tkeep),
    .in_stream_tlast(in_stream_tlast), .in_stream_tuser(in_stream_tuser),
    .in_stream_tvalid(in_stream_tvalid), .in_stream_tready(in_stream_tready),
    .r(r), .g(g), .b(b), .x(x), .y(y),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .frame_count(frame_count),
    .err_sof(err_sof), .err_eol(err_eol), .err_keep(err_keep), .err_clear(err_clear)
  );

  typedef struct {
    logic [31:0] d;
    logic        u;
    logic        l;
    logic [3:0]  k;
  } word_t;

  typedef struct {
    logic [7:0] r, g, b;
    logic [9:0] x;
    logic [8:0] y;
  } px_t;

  typedef struct {
    logic [31:0] d;
    logic        v, pr;
    logic        rdy, vld;
    logic [7:0]  r, g, b;
    logic [9:0]  x;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  word_t      wq[$];
  px_t        expq[$];
  logic [7:0] mpend[$];
  int         mx, my;
  logic [15:0] m_fc;
  logic       m_sof, m_eol, m_keep;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: bytes accumulate; every 3 form a pixel at the current raster position.
  task automatic model_word(input word_t w);
    px_t e;
    bit  hit_end;
    if (w.u) begin
      m_fc++;
      if (mpend.size() != 0 || mx != 0 || my != 0) begin
        m_sof = 1'b1;
        mpend.delete();
        mx = 0;
        my = 0;
      end
    end
`ifdef VIDEO_UNPACK_KEEP_CHECK_EN
    if (w.k != 4'hF) m_keep = 1'b1;
`endif
    for (int k = 0; k < 4; k++) mpend.push_back(w.d[8*k +: 8]);
    hit_end = 1'b0;
    while (mpend.size() >= 3) begin
      e.b = mpend.pop_front();
      e.g = mpend.pop_front();
      e.r = mpend.pop_front();
      e.x = 10'(mx);
      e.y = 9'(my);
      expq.push_back(e);
      if (mx == XS - 1) begin
        hit_end = 1'b1;
        mx = 0;
        my = (my == YS - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    if (w.l && !hit_end) begin
      m_eol = 1'b1;
      mpend.delete();
      mx = 0;
      my = (my == YS - 1) ? 0 : my + 1;
    end else if (!w.l && hit_end) begin
      m_eol = 1'b1;
    end
  endtask

  task automatic push_word(input word_t w);
    wq.push_back(w);
    model_word(w);
  endtask

  task automatic do_reset();
    aresetn = 1'b0; in_stream_tvalid = 1'b0; pix_ready = 1'b0; err_clear = 1'b0;
    in_stream_tdata = '0; in_stream_tkeep = 4'hF; in_stream_tlast = 1'b0; in_stream_tuser = 1'b0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    mx = 0; my = 0; m_fc = '0; m_sof = 1'b0; m_eol = 1'b0; m_keep = 1'b0;
    mpend.delete(); wq.delete(); expq.delete();
  endtask

  task automatic clear_errs();
    err_clear = 1'b1;
    @(posedge aclk);
    #1 err_clear = 1'b0;
    m_sof = 1'b0; m_eol = 1'b0; m_keep = 1'b0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_frame_count"}, frame_count, m_fc);
    chk({tag, "_err_sof"}, err_sof, m_sof);
    chk({tag, "_err_eol"}, err_eol, m_eol);
    chk({tag, "_err_keep"}, err_keep, m_keep);
  endtask

  // Test-pattern frame; one optional fault injected at (iln, iwd). An early tlast truncates that line.
  task automatic gen_frame(input int kind, input int iln, input int iwd);
    logic [7:0] lb [3*XS];
    logic [7:0] xv, yv;
    word_t w;
    for (int ln = 0; ln < YS; ln++) begin
      for (int p = 0; p < XS; p++) begin
        xv = 8'(p);
        yv = 8'(ln);
        lb[3*p]   = {1'b0, xv[6:0]} + {1'b0, yv[6:0]};
        lb[3*p+1] = yv;
        lb[3*p+2] = xv;
      end
      for (int wi = 0; wi < WPL; wi++) begin
        w.d = {lb[4*wi+3], lb[4*wi+2], lb[4*wi+1], lb[4*wi]};
        w.u = (ln == 0 && wi == 0) || (kind == K_SOF && ln == iln && wi == 0);
        w.l = (wi == WPL - 1);
        w.k = 4'hF;
        if (ln == iln && wi == iwd) begin
          if (kind == K_EOL)  w.l = 1'b1;
          if (kind == K_KEEP) w.k = 4'h7;
        end
        push_word(w);
        if (w.l) break;
      end
    end
  endtask

  task automatic run_stream(input int vp, input int pp, output int lows);
    int   budget;
    logic stall, acc;
    logic [42:0] held;
    px_t  e;
    budget = 0; stall = 1'b0; lows = 0; held = '0;
    while (wq.size() > 0 || expq.size() > 0) begin
      if (budget++ > 20000) begin
        n_tests++; n_fail++;
        $display("FAIL stream_timeout: %0d words and %0d pixels outstanding, expected 0", wq.size(), expq.size());
        wq.delete(); expq.delete();
        break;
      end
      in_stream_tvalid = (wq.size() > 0) && ($urandom_range(99) < vp);
      if (wq.size() > 0) begin
        in_stream_tdata = wq[0].d; in_stream_tuser = wq[0].u;
        in_stream_tlast = wq[0].l; in_stream_tkeep = wq[0].k;
      end
      pix_ready = ($urandom_range(99) < pp);
      @(negedge aclk);
      if (stall) chk("hold_stable", {r, g, b, x, y}, held);
      if (pix_valid && pix_ready) begin
        if (expq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_pixel: got x=%0d y=%0d, expected no pixel", x, y);
        end else begin
          e = expq.pop_front();
          chk("pixel", {r, g, b, x, y}, {e.r, e.g, e.b, e.x, e.y});
        end
      end
      stall = pix_valid && !pix_ready;
      held  = {r, g, b, x, y};
      if (in_stream_tvalid && !in_stream_tready) lows++;
      acc = in_stream_tvalid && in_stream_tready;
      @(posedge aclk);
      #1;
      if (acc) void'(wq.pop_front());
    end
    in_stream_tvalid = 1'b0;
    pix_ready = 1'b1;
    @(posedge aclk);
    #1 chk("no_trailing_pixel", pix_valid, 1'b0);
    pix_ready = 1'b0;
  endtask

  vec_t  vt [7];
  word_t w;
  int    lows;

  initial begin
    vt[0] = '{32'h44332211, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 8'h22, 8'h11, 10'd0};
    vt[1] = '{32'h88776655, 1'b1, 1'b1, 1'b1, 1'b1, 8'h66, 8'h55, 8'h44, 10'd1};
    vt[2] = '{32'hCCBBAA99, 1'b1, 1'b1, 1'b1, 1'b1, 8'h99, 8'h88, 8'h77, 10'd2};
    vt[3] = '{32'h00FFEEDD, 1'b1, 1'b1, 1'b0, 1'b1, 8'hCC, 8'hBB, 8'hAA, 10'd3};
    vt[4] = '{32'h00FFEEDD, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hEE, 8'hDD, 10'd4};
    vt[5] = '{32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hEE, 8'hDD, 10'd4};
    vt[6] = '{32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 10'd0};

    aresetn = 1'b0; in_stream_tvalid = 1'b0; pix_ready = 1'b0; err_clear = 1'b0;
    in_stream_tdata = '0; in_stream_tkeep = 4'hF; in_stream_tlast = 1'b0; in_stream_tuser = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_tready", in_stream_tready, 1'b0);
    chk("rst_pix_valid", pix_valid, 1'b0);
    chk("rst_pixel", {r, g, b, x, y}, 43'd0);
    chk("rst_frame_count", frame_count, 16'd0);
    chk("rst_errs", {err_sof, err_eol, err_keep}, 3'b000);

    // Directed vectors: phase walk, PH2B bubble, stall and drain
    aresetn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_stream_tdata = vt[i].d; in_stream_tvalid = vt[i].v; pix_ready = vt[i].pr;
      @(negedge aclk);
      chk("vec_tready", in_stream_tready, vt[i].rdy);
      @(posedge aclk);
      #1;
      chk("vec_valid", pix_valid, vt[i].vld);
      if (vt[i].vld) chk("vec_pixel", {r, g, b, x, y}, {vt[i].r, vt[i].g, vt[i].b, vt[i].x, 9'd0});
    end

    // Clean frame at full rate: one tready bubble per 3 words
    do_reset();
    gen_frame(K_NONE, 0, 0);
    run_stream(100, 100, lows);
    chk("clean_tready_bubbles", lows, 32'(YS * WPL / 3 - 1));
    check_status("clean");

    // Backpressure
    gen_frame(K_NONE, 0, 0);
    run_stream(80, 50, lows);
    check_status("bp");

    // Partial tkeep on one word
    gen_frame(K_KEEP, 2, 4);
    run_stream(90, 70, lows);
    check_status("keep");
    clear_errs();

    // Early tlast on a PH1 word of line 5, line truncated there
    gen_frame(K_EOL, 5, 7);
    run_stream(90, 60, lows);
    chk("eol_flag_set", err_eol, 1'b1);
    check_status("eol");
    clear_errs();
    chk("eol_flag_cleared", err_eol, 1'b0);

    // Early tlast on a PH2 word: both of its pixels emitted, then line restarts
    gen_frame(K_EOL, 3, 5);
    run_stream(100, 100, lows);
    check_status("eol_ph2");
    clear_errs();

    // Mid-frame tuser on first word of line 5
    gen_frame(K_SOF, 5, 0);
    run_stream(90, 60, lows);
    chk("sof_flag_set", err_sof, 1'b1);
    check_status("sof");
    clear_errs();

    // Random framing, data and keep
    for (int i = 0; i < 240; i++) begin
      w.d = $urandom;
      w.u = ($urandom_range(99) < 3);
      w.l = ($urandom_range(99) < 8);
      w.k = ($urandom_range(99) < 10) ? 4'($urandom) : 4'hF;
      push_word(w);
    end
    run_stream(60, 60, lows);
    check_status("rand");

    // Reset while in PH1 with a pixel stalled on the output
    do_reset();
    in_stream_tdata = 32'h44332211; in_stream_tuser = 1'b1; in_stream_tlast = 1'b0;
    in_stream_tkeep = 4'hF; in_stream_tvalid = 1'b1; pix_ready = 1'b0;
    @(posedge aclk);
    #1 in_stream_tvalid = 1'b0; in_stream_tuser = 1'b0;
    chk("pre_rst_valid", pix_valid, 1'b1);
    chk("pre_rst_frame_count", frame_count, 16'd1);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    chk("mid_rst_tready", in_stream_tready, 1'b0);
    chk("mid_rst_valid", pix_valid, 1'b0);
    chk("mid_rst_pixel", {r, g, b, x, y}, 43'd0);
    chk("mid_rst_frame_count", frame_count, 16'd0);
    aresetn = 1'b1;
    in_stream_tdata = 32'h00CCBBAA; in_stream_tvalid = 1'b1; pix_ready = 1'b1;
    @(posedge aclk);
    #1 in_stream_tvalid = 1'b0;
    chk("post_rst_valid", pix_valid, 1'b1);
    chk("post_rst_pixel", {r, g, b, x, y}, {8'hCC, 8'hBB, 8'hAA, 10'd0, 9'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_stream_unpacker.md
# video_stream_unpacker

Receiving end of the 32-bit AXI4-Stream video format emitted by the pixel generator's packer. It accepts packed 24-bit RGB words (4 pixels per 3 words, `tuser` = start of frame, `tlast` = end of line) and unpacks them into one pixel per handshake with its x/y coordinate. It tracks frame geometry, resynchronises on framing errors and exposes sticky error flags. It sits downstream of the pixel generator in loopback and verification builds, feeding a checker or a frame-buffer writer.

## Interface

Parameters:
- `X_SIZE`, 640, pixels per line; must be a multiple of 4.
- `Y_SIZE`, 480, lines per frame.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  synchronous, active-low reset.
- `in_stream_tdata`  in  32  packed pixel bytes.
- `in_stream_tkeep`  in  4  byte enables; only used under the configuration macro.
- `in_stream_tlast`  in  1  end of line.
- `in_stream_tuser`  in  1  start of frame.
- `in_stream_tvalid`  in  1  word valid.
- `in_stream_tready`  out  1  word accepted.
- `r`, `g`, `b`  out  8 each  pixel colour.
- `x`  out  10  pixel column.
- `y`  out  9  pixel row.
- `pix_valid`  out  1  pixel output valid.
- `pix_ready`  in  1  downstream accepts the pixel.
- `frame_count`  out  16  count of accepted `tuser` words; wraps at 65535.
- `err_sof`  out  1  sticky: `tuser` seen away from frame start.
- `err_eol`  out  1  sticky: `tlast` missing or misplaced.
- `err_keep`  out  1  sticky: partial `tkeep` (configuration macro only).
- `err_clear`  in  1  one-cycle pulse; clears all sticky errors.

## Operation

- **Byte order.** Stream byte k is `tdata[8(k%4)+7 : 8(k%4)]` of word k/4. Pixel i occupies bytes 3i..3i+2 as b, g, r, with b at the lowest byte.
- **Phase FSM** (reset state PH0):
  - PH0: pixel from bytes 0–2; byte 3 goes to the residue register. Next state PH1.
  - PH1: pixel = residue + bytes 0–1; bytes 2–3 go to the residue. Next state PH2.
  - PH2: pixel = residue + byte 0; bytes 1–3 go to the hold register. Next state PH2B.
  - PH2B: no word is consumed; the hold pixel moves to the output when the output register frees. Next state PH0.
- **Output register.** Single stage.
  - Loads when `!pix_valid || pix_ready`.
  - `in_stream_tready = aresetn && (!pix_valid || pix_ready) && state != PH2B`.
- **Position counters** `px`, `py` advance once per generated pixel and are registered into `x`/`y` together with the pixel.
  - `px` wraps at X_SIZE-1 and then increments `py`.
  - `py` wraps at Y_SIZE-1 to 0.
- **SOF handling.** On an accepted `tuser` word, `frame_count` increments. If the FSM is not at PH0 with px=0, py=0:
  - `err_sof` is set.
  - The FSM forces PH0, px=0, py=0 and discards the residue.
  - This word is decoded as pixel (0,0).
- **Early `tlast`** (accepted before the line's last word):
  - `err_eol` is set.
  - The residue is discarded and the FSM returns to PH0.
  - px=0 and py increments (with wrap) for the next word.
  - A pixel already decoded from the `tlast` word is still emitted.
- **Missing `tlast`** (last word of the line accepted without it): `err_eol` is set; geometry-driven wrap proceeds normally.
- **Error flags.** Set has priority over `err_clear` in the same cycle.

## Timing

- **Reset values:** `in_stream_tready`=0, `pix_valid`=0, `r`/`g`/`b`/`x`/`y`=0, `frame_count`=0, all error flags 0, FSM PH0, residue 0.
- **Latency:** a word accepted at edge N presents its pixel with `pix_valid`=1 from edge N. In PH2 the second pixel appears one cycle after the first is taken.
- **Throughput:** with `pix_ready`=1, 4 pixels per 4 cycles. `tready` is low exactly one cycle (PH2B) per 3 words.
- **Output stability:** while `pix_valid && !pix_ready`, `r`/`g`/`b`/`x`/`y` hold stable.
- **Reset mid-operation:** takes effect at the next edge, discards residue and hold, and drops `pix_valid` without a handshake.

## Configuration

- `VIDEO_UNPACK_KEEP_CHECK_EN` defined: any accepted word with `tkeep != 4'hF` sets `err_keep`. The word is still decoded normally.
- Not defined: `tkeep` is ignored and `err_keep` is tied to 0.

## Test plan

1. **Clean frame.** One 640×480 frame packed from r=x[7:0], g=y[7:0], b=x[6:0]+y[6:0], with `pix_ready`=1.
   - All 307200 pixels match, with correct x/y.
   - `frame_count`=1, no errors.
   - `tready` is low 1 cycle in every 4.
2. **Backpressure.** Random 50% `pix_ready`.
   - No pixel lost or duplicated.
   - Outputs stable while stalled.
   - Pixel sequence identical to scenario 1.
3. **Early `tlast`.** `tlast` on word 100 of line 5.
   - `err_eol`=1.
   - The next pixel after word 100's pixels is x=0, y=6.
   - `err_clear` then returns `err_eol` to 0.
4. **Mid-frame `tuser`.** `tuser` on the first word of line 10.
   - `err_sof`=1, `frame_count` increments.
   - That word's first pixel is x=0, y=0.
5. **Reset mid-line.** Reset asserted in PH1 with `pix_valid`=1.
   - All outputs are 0 during reset.
   - After release, the first word decodes as PH0, pixel (0,0).
6. **Partial `tkeep`.** `tkeep`=4'h7 on one word.
   - With `VIDEO_UNPACK_KEEP_CHECK_EN`: `err_keep`=1.
   - Without the macro: `err_keep`=0.
   - Pixel data is unaffected in both builds.
